// File: rtl/mt_pkg.sv
// Shared thread-tagging types and defaults for the barrel core fetch/decode/execute stages.
package mt_pkg;

    localparam int MT_NUM_THREADS = 8;
    localparam int MT_TID_W       = (MT_NUM_THREADS > 1) ? $clog2(MT_NUM_THREADS) : 1;
    localparam int MT_ADDR_W      = 32;
    localparam logic [MT_ADDR_W-1:0] MT_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INC = 4;

    typedef logic [MT_TID_W-1:0]  tid_t;
    typedef logic [MT_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mt_pc_sched_if.sv
// Fetch-PC scheduler bus: control/redirect inputs and the selected fetch slot.
// Spawn signals exist only when MT_PC_SPAWN_EN is defined.
interface mt_pc_sched_if #(
    parameter int NUM_THREADS   = 8,
    parameter int TID_W         = 3,
    parameter int ADDRESS_WIDTH = 32
);
    logic [NUM_THREADS-1:0]   thread_en;
    logic                     stall_f;
    logic                     pc_src_e;
    logic [TID_W-1:0]         branch_tid_e;
    logic [ADDRESS_WIDTH-1:0] pc_target_e;
    logic [ADDRESS_WIDTH-1:0] pc_f;
    logic [TID_W-1:0]         tid_f;
    logic                     valid_f;
`ifdef MT_PC_SPAWN_EN
    logic                     spawn_valid;
    logic [TID_W-1:0]         spawn_tid;
    logic [ADDRESS_WIDTH-1:0] spawn_pc;
`endif

    modport master (
        output thread_en, stall_f, pc_src_e, branch_tid_e, pc_target_e,
`ifdef MT_PC_SPAWN_EN
        output spawn_valid, spawn_tid, spawn_pc,
`endif
        input  pc_f, tid_f, valid_f
    );

    modport slave (
        input  thread_en, stall_f, pc_src_e, branch_tid_e, pc_target_e,
`ifdef MT_PC_SPAWN_EN
        input  spawn_valid, spawn_tid, spawn_pc,
`endif
        output pc_f, tid_f, valid_f
    );
endinterface

// File: rtl/rr_next_sel.sv
// Combinational rotating-priority finder: first set bit of mask_i after cur_i,
// wrapping back to cur_i itself; holds cur_i when the mask is empty.
module rr_next_sel #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] cur_i,
    output logic [IDX_W-1:0] nxt_o,
    output logic             any_o
);
    int j;

    always_comb begin
        nxt_o = cur_i;
        any_o = |mask_i;
        j     = 0;
        // Scan farthest first so the nearest enabled index is the last assignment.
        for (int k = N; k >= 1; k--) begin
            j = (int'(cur_i) + k) % N;
            if (mask_i[j[IDX_W-1:0]]) nxt_o = j[IDX_W-1:0];
        end
    end
endmodule

// File: rtl/mt_pc_sched.sv
// Multithreaded fetch PC unit: one PC per thread, round-robin fetch selection,
// execute-stage redirects. Optional thread spawning under MT_PC_SPAWN_EN.
module mt_pc_sched
    import mt_pkg::*;
#(
    parameter int NUM_THREADS   = MT_NUM_THREADS,
    parameter int TID_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    parameter int ADDRESS_WIDTH = MT_ADDR_W,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = ADDRESS_WIDTH'(MT_RESET_PC),
    parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = '0
) (
    input  logic         clk,
    input  logic         rst,
    mt_pc_sched_if.slave fif
);
    logic [NUM_THREADS-1:0][ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [TID_W-1:0]       cur_q, cur_d, nxt_sel;
    logic [NUM_THREADS-1:0] en_eff;
    logic                   any_en, fetch_inc;

`ifdef MT_PC_SPAWN_EN
    logic [NUM_THREADS-1:0] act_q, act_d;
    assign en_eff = fif.thread_en & act_q;
`else
    assign en_eff = fif.thread_en;
`endif

    assign fif.tid_f   = cur_q;
    assign fif.pc_f    = pc_q[cur_q];
    assign fif.valid_f = en_eff[cur_q];
    assign fetch_inc   = !fif.stall_f && en_eff[cur_q];

    rr_next_sel #(.N(NUM_THREADS), .IDX_W(TID_W)) u_sel (
        .mask_i (en_eff),
        .cur_i  (cur_q),
        .nxt_o  (nxt_sel),
        .any_o  (any_en)
    );

    always_comb begin
        cur_d = cur_q;
        pc_d  = pc_q;
`ifdef MT_PC_SPAWN_EN
        act_d = act_q;
`endif
        if (!fif.stall_f && any_en) cur_d = nxt_sel;
        // Later assignments win: spawn > redirect > increment on the same thread.
        // Out-of-range thread ids match no entry and are dropped.
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (fetch_inc && cur_q == TID_W'(i))
                pc_d[i] = pc_q[i] + ADDRESS_WIDTH'(PC_INC);
            if (fif.pc_src_e && fif.branch_tid_e == TID_W'(i))
                pc_d[i] = fif.pc_target_e;
`ifdef MT_PC_SPAWN_EN
            if (fif.spawn_valid && fif.spawn_tid == TID_W'(i)) begin
                pc_d[i]  = fif.spawn_pc;
                act_d[i] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q <= '0;
            for (int i = 0; i < NUM_THREADS; i++)
                pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * THREAD_PC_STRIDE;
`ifdef MT_PC_SPAWN_EN
            act_q <= NUM_THREADS'(1);
`endif
        end else begin
            cur_q <= cur_d;
            pc_q  <= pc_d;
`ifdef MT_PC_SPAWN_EN
            act_q <= act_d;
`endif
        end
    end
endmodule

// File: tb/tb_mt_pc_sched.sv
// Directed-vector bench for mt_pc_sched: round-robin order, redirects, stall,
// empty mask, PC wraparound, async reset and per-thread reset stride.
module tb_mt_pc_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mt_pc_sched_if #(.NUM_THREADS(8), .TID_W(3), .ADDRESS_WIDTH(32)) mif ();
    mt_pc_sched_if #(.NUM_THREADS(8), .TID_W(3), .ADDRESS_WIDTH(32)) sif ();

    mt_pc_sched dut (.clk(clk), .rst(rst), .fif(mif));

    mt_pc_sched #(.THREAD_PC_STRIDE(32'h1000)) dut_s (.clk(clk), .rst(rst), .fif(sif));

    typedef struct {
        logic [7:0]  en;
        logic        st;
        logic        src;
        logic [2:0]  bt;
        logic [31:0] tgt;
        logic [2:0]  etid;
        logic [31:0] epc;
        logic        ev;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [7:0] en, input logic st, input logic src,
                       input logic [2:0] bt, input logic [31:0] tgt,
                       input logic [2:0] etid, input logic [31:0] epc, input logic ev);
        vec_t v;
        v.en = en; v.st = st; v.src = src; v.bt = bt; v.tgt = tgt;
        v.etid = etid; v.epc = epc; v.ev = ev;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [2:0] etid,
                           input logic [31:0] epc, input logic ev);
        chk({nm, " tid"},   32'(mif.tid_f),   32'(etid));
        chk({nm, " pc"},    mif.pc_f,         epc);
        chk({nm, " valid"}, 32'(mif.valid_f), 32'(ev));
    endtask

    initial begin
        // Full mask: visit every thread once, thread 0 again at +4
        for (int i = 0; i < 8; i++) add(8'hFF, 0, 0, 0, 0, 3'(i), 0, 1);
        add(8'hFF, 0, 0, 0, 0, 0, 32'h4, 1);
        // Sparse mask 0010_0101
        add(8'h25, 0, 0, 0, 0, 1, 32'h4, 0);
        add(8'h25, 0, 0, 0, 0, 2, 32'h4, 1);
        add(8'h25, 0, 0, 0, 0, 5, 32'h4, 1);
        add(8'h25, 0, 0, 0, 0, 0, 32'h8, 1);
        add(8'h25, 0, 0, 0, 0, 2, 32'h8, 1);
        add(8'h25, 0, 0, 0, 0, 5, 32'h8, 1);
        add(8'h25, 0, 0, 0, 0, 0, 32'hC, 1);
        // Redirect on the incremented thread, then to another thread in parallel
        add(8'hFF, 0, 0, 0, 0,        2, 32'hC,   1);
        add(8'hFF, 0, 1, 3, 32'h100,  3, 32'h4,   1);
        add(8'hFF, 0, 0, 0, 0,        4, 32'h4,   1);
        add(8'hFF, 0, 0, 0, 0,        5, 32'hC,   1);
        add(8'hFF, 0, 0, 0, 0,        6, 32'h4,   1);
        add(8'hFF, 0, 0, 0, 0,        7, 32'h4,   1);
        add(8'hFF, 0, 0, 0, 0,        0, 32'h10,  1);
        add(8'hFF, 0, 1, 2, 32'h202,  1, 32'h4,   1);
        add(8'hFF, 0, 0, 0, 0,        2, 32'h202, 1);
        add(8'hFF, 0, 0, 0, 0,        3, 32'h100, 1);
        // Stall three cycles with a redirect to thread 6
        add(8'hFF, 1, 1, 6, 32'h600,  4, 32'h8,   1);
        add(8'hFF, 1, 0, 0, 0,        4, 32'h8,   1);
        add(8'hFF, 1, 0, 0, 0,        4, 32'h8,   1);
        add(8'hFF, 0, 0, 0, 0,        4, 32'h8,   1);
        add(8'hFF, 0, 0, 0, 0,        5, 32'h10,  1);
        add(8'hFF, 0, 0, 0, 0,        6, 32'h600, 1);
        // Empty mask holds; redirect still lands on a disabled thread
        add(8'h00, 0, 0, 0, 0,        7, 32'h8,   0);
        add(8'h00, 0, 1, 7, 32'h700,  7, 32'h8,   0);
        add(8'h00, 0, 0, 0, 0,        7, 32'h700, 0);
        // Only thread 4 enabled
        add(8'h10, 0, 0, 0, 0,        7, 32'h700, 0);
        add(8'h10, 0, 0, 0, 0,        4, 32'hC,   1);
        add(8'h10, 0, 0, 0, 0,        4, 32'h10,  1);
        add(8'h10, 0, 0, 0, 0,        4, 32'h14,  1);
        add(8'hFF, 0, 0, 0, 0,        4, 32'h18,  1);
        // PC wraps modulo 2^32
        add(8'hFF, 0, 1, 5, 32'hFFFF_FFFC, 5, 32'h14, 1);
        add(8'h20, 0, 0, 0, 0,        6, 32'h604, 0);
        add(8'h20, 0, 0, 0, 0,        5, 32'hFFFF_FFFC, 1);
        add(8'h20, 0, 0, 0, 0,        5, 32'h0,   1);

        rst = 1'b1;
        mif.thread_en = 8'hFF; mif.stall_f = 0; mif.pc_src_e = 0;
        mif.branch_tid_e = 0; mif.pc_target_e = 0;
        sif.thread_en = 8'h00; sif.stall_f = 0; sif.pc_src_e = 0;
        sif.branch_tid_e = 0; sif.pc_target_e = 0;
`ifdef MT_PC_SPAWN_EN
        mif.spawn_valid = 0; mif.spawn_tid = 0; mif.spawn_pc = 0;
        sif.spawn_valid = 0; sif.spawn_tid = 0; sif.spawn_pc = 0;
`endif
        #1;
        chk_out("reset", 0, 32'h0, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            mif.thread_en    = vq[i].en;
            mif.stall_f      = vq[i].st;
            mif.pc_src_e     = vq[i].src;
            mif.branch_tid_e = vq[i].bt;
            mif.pc_target_e  = vq[i].tgt;
            #1;
            chk_out($sformatf("v%0d", i), vq[i].etid, vq[i].epc, vq[i].ev);
            @(negedge clk);
        end

        // Asynchronous reset between edges returns outputs immediately
        mif.thread_en = 8'hFF; mif.stall_f = 0; mif.pc_src_e = 0;
        sif.thread_en = 8'h04;
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 32'h0, 1);
        chk("stride t0 pc",    sif.pc_f,          32'h0);
        chk("stride t0 valid", 32'(sif.valid_f),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("post_rst0", 0, 32'h0, 1);
        @(negedge clk);
        #1;
        chk_out("post_rst1", 1, 32'h0, 1);
        chk("stride t2 tid", 32'(sif.tid_f), 32'h2);
        chk("stride t2 pc",  sif.pc_f,       32'h2000);
        @(negedge clk);
        #1;
        chk_out("post_rst2", 2, 32'h0, 1);
        chk("stride t2 pc+4", sif.pc_f, 32'h2004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mt_pc_sched.md
Name: mt_pc_sched

Overview:
Parametrised multithreaded fetch PC unit for the barrel core; successor to the fixed 8-thread PC block.
- Holds one PC per hardware thread.
- Selects the thread to fetch each cycle by round-robin over an enable mask, skipping disabled threads.
- Applies execute-stage branch redirects to any thread.
- Sits at the front of the fetch stage; pc_f/tid_f drive instruction memory and the F/D pipeline register.

Parameters:
NUM_THREADS, 8, number of hardware threads (>=1).
TID_W, $clog2(NUM_THREADS) (min 1), thread-id width.
ADDRESS_WIDTH, 32, PC width.
RESET_PC, 32'h0000_0000, reset PC base.
THREAD_PC_STRIDE, 32'h0000_0000, per-thread reset offset: PC[i] resets to RESET_PC + i*THREAD_PC_STRIDE.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
thread_en  in  NUM_THREADS  per-thread fetch enable mask
stall_f  in  1  freeze fetch: no PC increment, no thread advance
pc_src_e  in  1  branch/jump taken in execute
branch_tid_e  in  TID_W  thread owning the taken branch
pc_target_e  in  ADDRESS_WIDTH  redirect target
pc_f  out  ADDRESS_WIDTH  PC of the currently selected thread
tid_f  out  TID_W  currently selected thread
valid_f  out  1  the fetch slot is real (thread_en[tid_f])

Behaviour:
Interface:
- One clock, clk; reset is asynchronous and active-high, rst. Polarity and synchronicity are fixed.

Reset (async, immediate):
- pc_q[i] = RESET_PC + i*THREAD_PC_STRIDE.
- cur_q = 0.
- pc_f = pc_q[0]; tid_f = 0; valid_f = thread_en[0].

Outputs:
- Combinational from state: tid_f = cur_q, pc_f = pc_q[cur_q], valid_f = thread_en[cur_q].

Each rising edge with stall_f=0:
- If valid_f, pc_q[cur_q] <= pc_q[cur_q] + 4 (mod 2^ADDRESS_WIDTH).
- cur_q <= first enabled thread searching cur_q+1 .. NUM_THREADS-1, then 0 .. cur_q (rotating priority; returns cur_q itself if it is the only enabled thread).
- If thread_en is all zero, cur_q holds and valid_f=0; no PC changes.

stall_f=1:
- cur_q and all increments are frozen.
- Redirects still apply.

Redirect (pc_src_e=1):
- pc_q[branch_tid_e] <= pc_target_e on that edge, regardless of stall_f or thread_en.
- If the redirect targets the thread being incremented on the same edge, the redirect wins (no +4).
- A redirect to a different thread occurs in parallel with the increment.
- branch_tid_e >= NUM_THREADS (non-power-of-2 counts): ignored.

Other rules:
- No alignment enforcement; the target is stored verbatim.
- thread_en may change any cycle; it takes effect on the next selection and the current valid_f immediately.
- A disabled thread's PC is preserved.
- Latency: redirect is visible on pc_f the cycle after it is applied, when that thread is selected.

Optional Feature:
MT_PC_SPAWN_EN
- Adds ports spawn_valid (in, 1), spawn_tid (in, TID_W), spawn_pc (in, ADDRESS_WIDTH), plus an internal active mask act_q.
- act_q resets to 1 for thread 0 only.
- Effective enable = thread_en & act_q.
- spawn_valid on an edge sets act_q[spawn_tid] and pc_q[spawn_tid] <= spawn_pc.
- Priority on the same thread: spawn > redirect > increment.
- Without the macro: no spawn ports; effective enable = thread_en.

Decomposition:
- Package mt_pkg: NUM_THREADS default, TID_W, ADDRESS_WIDTH, RESET_PC, PC_INC (=4), tid_t and addr_t typedefs. Shared with the decode/execute thread-tagged stages.
- One sub-module, rr_next_sel: combinational rotating-priority finder. Inputs: mask, current index. Outputs: next index, any_valid. Reusable for the writeback arbiter.

Test Plan:
- Reset with thread_en=8'hFF, defaults -> tid_f cycles 0,1,...,7,0; thread 0 shows pc_f 0 then 4 on its second visit; all threads reach 4 after 8 cycles.
- thread_en=8'b0010_0101 -> tid_f sequence 0,2,5,0,2,5; valid_f=1 throughout; threads 1,3,4,6,7 keep PC 0.
- pc_src_e=1, branch_tid_e=3, pc_target_e=32'h100 on the edge thread 3 is incremented -> next visit to thread 3 shows pc_f=32'h100 (not 32'h104 and not +4).
- stall_f=1 for 3 cycles with a redirect to thread 6 -> tid_f and pc_f frozen; after release, thread 6 fetches the target.
- thread_en=0 -> valid_f=0, tid_f holds, no PC changes. Re-enabling only thread 4 -> tid_f=4 repeatedly, pc_f +4 per cycle.
- Assert rst mid-run (asynchronously, between edges) -> outputs return to tid_f=0, pc_f=RESET_PC immediately. With THREAD_PC_STRIDE=32'h1000, thread 2 resets to 32'h2000.
